// File: rtl/timer_pkg.sv
// Shared widths and constants for the timestamp timer and its capture channels.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

  // Default geometry of the timer block
  localparam int CNT_W_DEF  = 32;
  localparam int DIV_W_DEF  = 24;
  localparam int TICK_W_DEF = 16;
  localparam int NUM_CH_DEF = 4;

  // Widest counter supported; CAP_ALL_ONES is sliced down to CNT_W by users
  localparam int CAP_MAX_W = 64;
  localparam logic [CAP_MAX_W-1:0] CAP_ALL_ONES = '1;

endpackage

// File: rtl/timer_cap_ch.sv
// One capture channel: rising-edge detect on trigger, latches count, holds until ack.
// Latency: data/valid/ovr update one cycle after the trigger edge or ack.
// Backpressure: none; an edge arriving while a value is unacknowledged sets sticky ovr.
module timer_cap_ch
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_trig,
  input  logic             i_ack,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_data,
  output logic             o_ovr
);

  logic             r_trig_q;
  logic             r_valid;
  logic [CNT_W-1:0] r_data;
  logic             r_ovr;
  logic             w_edge;

  assign w_edge = i_trig & ~r_trig_q;

  // Trigger history keeps sampling through clr so a trigger held across clr
  // does not look like a fresh edge afterwards.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_trig_q <= 1'b0;
    end else begin
      r_trig_q <= i_trig;
    end
  end

  // Capture/ack/overflow state; an edge coinciding with clr is dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ovr   <= 1'b0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ovr   <= 1'b0;
    end else if (w_edge) begin
      // An ack in the same cycle frees the slot for the new timestamp
      if (!r_valid || i_ack) begin
        r_data  <= i_count;
        r_valid <= 1'b1;
      end else begin
        r_ovr   <= 1'b1;
      end
    end else if (i_ack) begin
      // Ack on an empty channel is harmless: valid is already low
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ovr   = r_ovr;

endmodule

// File: rtl/timer_tick_capture.sv
// Free-running timestamp counter, programmable tick prescaler, tick counter and NUM_CH capture channels.
// Latency: all outputs registered; pulses and captures appear one cycle after the causing edge.
// Backpressure: none; counters free-run on ena, lost captures are flagged per channel in cap_ovr.
module timer_tick_capture
  import timer_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int TICK_W = TICK_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    ena,
  input  logic [DIV_W-1:0]        tick_div,
  input  logic [NUM_CH-1:0]       cap_trig,
  input  logic [NUM_CH-1:0]       cap_ack,
  output logic [CNT_W-1:0]        count,
  output logic                    pulse_full,
  output logic                    pulse_tick,
  output logic [TICK_W-1:0]       cnt_tick,
  output logic [NUM_CH-1:0]       cap_valid,
  output logic [NUM_CH*CNT_W-1:0] cap_data,
  output logic [NUM_CH-1:0]       cap_ovr
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
  // CNT_W must not exceed CAP_MAX_W for this slice to be meaningful
  localparam logic [CNT_W-1:0]  CNT_MAX  = CAP_ALL_ONES[CNT_W-1:0];

  logic [CNT_W-1:0]  r_count;
  logic              r_pulse_full;
  logic [DIV_W-1:0]  r_div_cnt;
  logic              r_pulse_tick;
  logic [TICK_W-1:0] r_cnt_tick;
  logic              w_at_max;
  logic              w_div_hit;

  assign w_at_max  = (r_count == CNT_MAX);
  // '>=' lets a lowered tick_div take effect without waiting for a full wrap
  assign w_div_hit = (r_div_cnt >= tick_div);

  // Main timestamp counter; natural binary wrap from all-ones to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (ena) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  // Wrap pulse, gated by ena so a held all-ones count pulses only once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pulse_full <= 1'b0;
    end else if (clr) begin
      r_pulse_full <= 1'b0;
    end else begin
      r_pulse_full <= ena & w_at_max;
    end
  end

  // Prescaler: tick every tick_div+1 enabled cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div_cnt    <= '0;
      r_pulse_tick <= 1'b0;
    end else if (clr) begin
      r_div_cnt    <= '0;
      r_pulse_tick <= 1'b0;
    end else if (ena && w_div_hit) begin
      r_div_cnt    <= '0;
      r_pulse_tick <= 1'b1;
    end else begin
      if (ena) begin
        r_div_cnt <= r_div_cnt + DIV_ONE;
      end
      r_pulse_tick <= 1'b0;
    end
  end

  // Tick counter follows the registered tick pulse, independent of ena.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt_tick <= '0;
    end else if (clr) begin
      r_cnt_tick <= '0;
    end else if (r_pulse_tick) begin
      r_cnt_tick <= r_cnt_tick + TICK_ONE;
    end
  end

  assign count      = r_count;
  assign pulse_full = r_pulse_full;
  assign pulse_tick = r_pulse_tick;
  assign cnt_tick   = r_cnt_tick;

  // Channels see the pre-increment count of the edge cycle
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_cap_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_clr   (clr),
      .i_trig  (cap_trig[g]),
      .i_ack   (cap_ack[g]),
      .i_count (r_count),
      .o_valid (cap_valid[g]),
      .o_data  (cap_data[g*CNT_W +: CNT_W]),
      .o_ovr   (cap_ovr[g])
    );
  end

endmodule

// File: tb/tb_timer_tick_capture.sv
// Randomised and directed checks of timer_tick_capture against a cycle-level behavioural model.
// Latency: model advances once per clock edge; outputs compared 1 time unit after the edge.
// Backpressure: n/a.
module tb_timer_tick_capture;

  localparam int CW = 8;
  localparam int DW = 8;
  localparam int TW = 8;
  localparam int NC = 4;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             ena;
  logic [DW-1:0]    tick_div;
  logic [NC-1:0]    cap_trig;
  logic [NC-1:0]    cap_ack;
  logic [CW-1:0]    count;
  logic             pulse_full;
  logic             pulse_tick;
  logic [TW-1:0]    cnt_tick;
  logic [NC-1:0]    cap_valid;
  logic [NC*CW-1:0] cap_data;
  logic [NC-1:0]    cap_ovr;

  timer_tick_capture #(
    .CNT_W  (CW),
    .DIV_W  (DW),
    .TICK_W (TW),
    .NUM_CH (NC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .ena        (ena),
    .tick_div   (tick_div),
    .cap_trig   (cap_trig),
    .cap_ack    (cap_ack),
    .count      (count),
    .pulse_full (pulse_full),
    .pulse_tick (pulse_tick),
    .cnt_tick   (cnt_tick),
    .cap_valid  (cap_valid),
    .cap_data   (cap_data),
    .cap_ovr    (cap_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model state (plain integers, modulo arithmetic)
  int m_count, m_div, m_ticks;
  bit m_pf, m_pt;
  bit m_valid [NC];
  int m_data  [NC];
  bit m_ovr   [NC];
  bit m_prev  [NC];

  task automatic model_step();
    bit edge_seen [NC];
    int old_count;
    bit old_pt;
    if (!rst) begin
      m_count = 0; m_div = 0; m_ticks = 0; m_pf = 0; m_pt = 0;
      for (int c = 0; c < NC; c++) begin
        m_valid[c] = 0; m_data[c] = 0; m_ovr[c] = 0; m_prev[c] = 0;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        edge_seen[c] = cap_trig[c] && !m_prev[c];
        m_prev[c]    = cap_trig[c];
      end
      if (clr) begin
        m_count = 0; m_div = 0; m_ticks = 0; m_pf = 0; m_pt = 0;
        for (int c = 0; c < NC; c++) begin
          m_valid[c] = 0; m_data[c] = 0; m_ovr[c] = 0;
        end
      end else begin
        old_count = m_count;
        old_pt    = m_pt;
        m_pf      = ena && (m_count == 255);
        if (ena) m_count = (m_count + 1) % 256;
        if (ena && m_div >= int'(tick_div)) begin
          m_div = 0;
          m_pt  = 1;
        end else begin
          if (ena) m_div = m_div + 1;
          m_pt = 0;
        end
        if (old_pt) m_ticks = (m_ticks + 1) % 256;
        for (int c = 0; c < NC; c++) begin
          if (edge_seen[c]) begin
            if (!m_valid[c] || cap_ack[c]) begin
              m_data[c]  = old_count;
              m_valid[c] = 1;
            end else begin
              m_ovr[c] = 1;
            end
          end else if (cap_ack[c]) begin
            m_valid[c] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [NC-1:0]    ev, eo;
    logic [NC*CW-1:0] ed;
    for (int c = 0; c < NC; c++) begin
      ev[c] = m_valid[c];
      eo[c] = m_ovr[c];
      ed[c*CW +: CW] = CW'(m_data[c]);
    end
    chk("count",      32'(count),      32'(m_count));
    chk("pulse_full", 32'(pulse_full), 32'(m_pf));
    chk("pulse_tick", 32'(pulse_tick), 32'(m_pt));
    chk("cnt_tick",   32'(cnt_tick),   32'(m_ticks));
    chk("cap_valid",  32'(cap_valid),  32'(ev));
    chk("cap_data",   32'(cap_data),   32'(ed));
    chk("cap_ovr",    32'(cap_ovr),    32'(eo));
  endtask

  task automatic cyc(input logic r, input logic c, input logic e, input logic [DW-1:0] d,
                     input logic [NC-1:0] t, input logic [NC-1:0] a);
    @(negedge clk);
    rst = r; clr = c; ena = e; tick_div = d; cap_trig = t; cap_ack = a;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Advance with ena=1 until the model count reaches n (bounded)
  task automatic run_to(input int n, input logic [DW-1:0] d);
    for (int k = 0; k < 300 && m_count != n; k++) cyc(1, 0, 1, d, '0, '0);
  endtask

  initial begin
    rst = 0; clr = 0; ena = 0; tick_div = '0; cap_trig = '0; cap_ack = '0;

    // Reset state
    cyc(0, 0, 0, 8'd0, '0, '0);
    cyc(0, 0, 1, 8'd3, 4'hF, '0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(cap_valid), 32'd0);

    // Activity then a single reset cycle
    for (int i = 0; i < 20; i++) cyc(1, 0, 1, 8'd1, 4'($urandom_range(0, 15)), '0);
    cyc(0, 0, 1, 8'd1, '0, '0);
    chk("rst2_count", 32'(count), 32'd0);
    chk("rst2_tick",  32'(cnt_tick), 32'd0);
    chk("rst2_data",  32'(cap_data), 32'd0);
    chk("rst2_ovr",   32'(cap_ovr), 32'd0);

    // clr with ena in the same cycle
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 8'd7, '0, '0);
    cyc(1, 1, 1, 8'd7, '0, '0);
    chk("clr_count0", 32'(count), 32'd0);

    // Wrap and held all-ones
    for (int i = 0; i < 255; i++) cyc(1, 0, 1, 8'd7, '0, '0);
    chk("wrap_255", 32'(count), 32'd255);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 8'd7, '0, '0);
      chk("hold_nopulse", 32'(pulse_full), 32'd0);
    end
    cyc(1, 0, 1, 8'd7, '0, '0);
    chk("wrap_zero", 32'(count), 32'd0);
    chk("wrap_pulse", 32'(pulse_full), 32'd1);
    cyc(1, 0, 1, 8'd7, '0, '0);
    chk("wrap_pulse_once", 32'(pulse_full), 32'd0);

    // Prescaler tick_div=4
    cyc(1, 1, 0, 8'd4, '0, '0);
    for (int i = 0; i < 15; i++) begin
      cyc(1, 0, 1, 8'd4, '0, '0);
      chk("tick_pos", 32'(pulse_tick), 32'((i % 5) == 4));
    end
    cyc(1, 0, 1, 8'd4, '0, '0);
    chk("tick_cnt3", 32'(cnt_tick), 32'd3);

    // Lowered tick_div takes effect at once; tick_div=0 ticks every cycle
    cyc(1, 1, 0, 8'd9, '0, '0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 1, 8'd9, '0, '0);
    chk("div9_nopulse", 32'(pulse_tick), 32'd0);
    cyc(1, 0, 1, 8'd2, '0, '0);
    chk("div_lowered", 32'(pulse_tick), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 8'd0, '0, '0);
      chk("div0_every", 32'(pulse_tick), 32'd1);
    end

    // Capture, overflow, edge+ack, ack
    cyc(1, 1, 0, 8'd5, '0, '0);
    run_to(100, 8'd5);
    cyc(1, 0, 1, 8'd5, 4'b0001, '0);
    chk("cap100_valid", 32'(cap_valid[0]), 32'd1);
    chk("cap100_data",  32'(cap_data[7:0]), 32'd100);
    run_to(120, 8'd5);
    cyc(1, 0, 1, 8'd5, 4'b0001, '0);
    chk("ovr_set",  32'(cap_ovr[0]), 32'd1);
    chk("ovr_data", 32'(cap_data[7:0]), 32'd100);
    run_to(130, 8'd5);
    cyc(1, 0, 1, 8'd5, 4'b0001, 4'b0001);
    chk("edgeack_valid", 32'(cap_valid[0]), 32'd1);
    chk("edgeack_data",  32'(cap_data[7:0]), 32'd130);
    cyc(1, 0, 1, 8'd5, '0, 4'b0001);
    chk("ack_valid0", 32'(cap_valid[0]), 32'd0);
    chk("ack_hold",   32'(cap_data[7:0]), 32'd130);
    cyc(1, 0, 1, 8'd5, '0, 4'b0001);
    chk("ovr_sticky", 32'(cap_ovr[0]), 32'd1);

    // Held trigger captures once
    cyc(1, 0, 1, 8'd5, 4'b0010, '0);
    cyc(1, 0, 1, 8'd5, 4'b0010, 4'b0010);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 8'd5, 4'b0010, '0);
    chk("held_once", 32'(cap_valid[1]), 32'd0);

    // Trigger edge with clr is dropped, no false edge afterwards
    cyc(1, 1, 1, 8'd5, 4'b0100, '0);
    cyc(1, 0, 1, 8'd5, 4'b0100, '0);
    chk("clr_edge_drop", 32'(cap_valid[2]), 32'd0);

    // All channels capture the same count
    cyc(1, 0, 1, 8'd5, '0, '0);
    run_to(50, 8'd5);
    cyc(1, 0, 1, 8'd5, 4'hF, '0);
    chk("all_valid", 32'(cap_valid), 32'hF);
    chk("all_data",  32'(cap_data), 32'h32323232);

    // Randomised traffic
    begin
      logic [DW-1:0] d;
      d = 8'd3;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 49) == 0) d = 8'($urandom_range(0, 12));
        cyc(($urandom_range(0, 499) != 0),
            ($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) != 0),
            d,
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15) & $urandom_range(0, 15)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
